// File: rtl/pil_ctrl.sv
// Priority interrupt controller: PIE/PID registers, level select and the
// request/acknowledge handshake that moves the program level (PIL).
module pil_ctrl #(
  parameter int NLEV = 16,
  parameter int LVLW = $clog2(NLEV),
  parameter int SYNC = 2
) (
  input  logic            clk,
  input  logic            MCL_n,
  input  logic            SI,
  input  logic            T3,
  input  logic            ION,
  input  logic [NLEV-1:0] int_req,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [NLEV-1:0] wr_data,
  input  logic            chg_ack,
  output logic            PILKL,
  output logic [LVLW-1:0] PIL,
  output logic [NLEV-1:0] PIE,
  output logic [NLEV-1:0] PID,
  output logic            chg_req,
  output logic [LVLW-1:0] new_lvl
);

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  state_t                     state;
  logic [SYNC-1:0][NLEV-1:0]  sync_reg;
  logic [NLEV-1:0]            prev_reg;
  logic [NLEV-1:0]            hw_edge;
  logic [NLEV-1:0]            pid_set;
  logic [NLEV-1:0]            pid_clr;
  logic [NLEV-1:0]            act;
  logic [LVLW-1:0]            top;

  assign PILKL   = ~SI & T3;
  assign hw_edge = sync_reg[SYNC-1] & ~prev_reg;
  assign pid_set = (wr_en && wr_sel == 2'd1) ? wr_data : '0;
  assign pid_clr = (wr_en && wr_sel == 2'd2) ? wr_data : '0;
  assign act     = PID & PIE;

  // Highest set bit wins; an empty act vector selects level 0.
  always_comb begin
    top = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (act[i]) top = LVLW'(i);
    end
  end

  always_ff @(posedge clk or negedge MCL_n) begin
    if (!MCL_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], int_req};
      prev_reg <= sync_reg[SYNC-1];
    end
  end

  // Hardware edge is OR-ed in after the clear so a colliding edge survives.
  always_ff @(posedge clk or negedge MCL_n) begin
    if (!MCL_n) begin
      PIE <= '0;
      PID <= '0;
    end else begin
      if (wr_en && wr_sel == 2'd0) PIE <= wr_data;
      PID <= ((PID | pid_set) & ~pid_clr) | hw_edge;
    end
  end

  always_ff @(posedge clk or negedge MCL_n) begin
    if (!MCL_n) begin
      state   <= IDLE;
      PIL     <= '0;
      chg_req <= 1'b0;
      new_lvl <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PILKL && ION && top != PIL) begin
            new_lvl <= top;
            chg_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Target stays frozen; ION loss does not cancel a pending change.
          if (chg_ack) begin
            PIL     <= new_lvl;
            chg_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pil_ctrl.sv
// Directed bench for pil_ctrl: reset, edge latency, priority, gating,
// set/clear collision, downward changes and asynchronous reset mid-request.
module tb_pil_ctrl;

  logic        clk = 1'b0;
  logic        MCL_n;
  logic        SI, T3, ION;
  logic [15:0] int_req;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic        chg_ack;
  logic        PILKL;
  logic [3:0]  PIL;
  logic [15:0] PIE, PID;
  logic        chg_req;
  logic [3:0]  new_lvl;

  int n_cmp = 0;
  int n_err = 0;

  pil_ctrl #(.NLEV(16), .LVLW(4), .SYNC(2)) dut (
    .clk(clk), .MCL_n(MCL_n), .SI(SI), .T3(T3), .ION(ION),
    .int_req(int_req), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .chg_ack(chg_ack), .PILKL(PILKL), .PIL(PIL), .PIE(PIE), .PID(PID),
    .chg_req(chg_req), .new_lvl(new_lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic strobe();
    SI = 1'b0; T3 = 1'b1;
    @(negedge clk);
    T3 = 1'b0;
  endtask

  task automatic ack();
    chg_ack = 1'b1;
    @(negedge clk);
    chg_ack = 1'b0;
  endtask

  initial begin
    MCL_n = 1'b0; SI = 1'b1; T3 = 1'b0; ION = 1'b1; int_req = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; chg_ack = 1'b0;
    step(2);
    chk("rst_pil", 32'(PIL), 0);
    chk("rst_pie", 32'(PIE), 0);
    chk("rst_pid", 32'(PID), 0);
    chk("rst_req", 32'(chg_req), 0);
    chk("rst_newlvl", 32'(new_lvl), 0);
    MCL_n = 1'b1;
    step(1);

    // Reserved write select does nothing
    wr(2'd3, 16'hFFFF);
    chk("wsel3_pie", 32'(PIE), 0);
    chk("wsel3_pid", 32'(PID), 0);

    // PILKL combinational gating
    SI = 1'b1; T3 = 1'b1; #1;
    chk("pilkl_si1", 32'(PILKL), 0);
    SI = 1'b0; #1;
    chk("pilkl_t3", 32'(PILKL), 1);
    T3 = 1'b0; #1;
    chk("pilkl_t3lo", 32'(PILKL), 0);
    step(1);

    // Edge latency on level 10
    wr(2'd0, 16'h0400);
    chk("pie_0400", 32'(PIE), 32'h0400);
    int_req[10] = 1'b1;
    step(1);
    int_req[10] = 1'b0;
    step(1);
    chk("lat_2clk", 32'(PID), 0);
    step(1);
    chk("lat_3clk", 32'(PID), 32'h0400);

    // Gating: ION=0, then SI=1 with T3
    ION = 1'b0;
    strobe();
    chk("gate_ion0", 32'(chg_req), 0);
    ION = 1'b1;
    SI = 1'b1; T3 = 1'b1;
    step(1);
    T3 = 1'b0;
    chk("gate_si1", 32'(chg_req), 0);
    strobe();
    chk("req10", 32'(chg_req), 1);
    chk("newlvl10", 32'(new_lvl), 10);
    ack();
    chk("pil10", 32'(PIL), 10);
    chk("req10_done", 32'(chg_req), 0);
    ack();
    chk("ack_idle_pil", 32'(PIL), 10);

    // Priority and frozen target
    wr(2'd0, 16'hFFFF);
    wr(2'd1, 16'h2402);
    chk("pid_2402", 32'(PID), 32'h2402);
    strobe();
    chk("newlvl13", 32'(new_lvl), 13);
    wr(2'd2, 16'h2000);
    chk("pid_0402", 32'(PID), 32'h0402);
    chk("frozen13", 32'(new_lvl), 13);
    ION = 1'b0;
    step(1);
    chk("ion_drop_req", 32'(chg_req), 1);
    ION = 1'b1;
    ack();
    chk("pil13", 32'(PIL), 13);
    strobe();
    chk("down_newlvl10", 32'(new_lvl), 10);
    ack();
    chk("pil10b", 32'(PIL), 10);

    // Downward: 13 -> 1 -> 0
    wr(2'd1, 16'h2000);
    strobe();
    ack();
    chk("pil13b", 32'(PIL), 13);
    wr(2'd2, 16'h2400);
    chk("pid_0002", 32'(PID), 32'h0002);
    chk("no_req_wo_strobe", 32'(chg_req), 0);
    strobe();
    chk("newlvl1", 32'(new_lvl), 1);
    ack();
    chk("pil1", 32'(PIL), 1);
    wr(2'd2, 16'h0002);
    strobe();
    chk("newlvl0", 32'(new_lvl), 0);
    chk("req_empty", 32'(chg_req), 1);
    ack();
    chk("pil0", 32'(PIL), 0);

    // Collision: edge and clear of bit 5 on the same clock
    int_req[5] = 1'b1;
    step(2);
    wr(2'd2, 16'h0020);
    chk("collide_set", 32'(PID), 32'h0020);
    wr(2'd2, 16'h0020);
    chk("held_clear", 32'(PID), 0);
    step(3);
    chk("held_noreset", 32'(PID), 0);
    int_req[5] = 1'b0;
    step(1);

    // Async reset while a request is pending
    wr(2'd1, 16'h0100);
    strobe();
    ack();
    chk("pil8", 32'(PIL), 8);
    wr(2'd1, 16'h0800);
    strobe();
    chk("req11", 32'(chg_req), 1);
    chk("newlvl11", 32'(new_lvl), 11);
    #2;
    MCL_n = 1'b0;
    #1;
    chk("arst_req", 32'(chg_req), 0);
    chk("arst_pil", 32'(PIL), 0);
    chk("arst_pie", 32'(PIE), 0);
    chk("arst_pid", 32'(PID), 0);
    chk("arst_newlvl", 32'(new_lvl), 0);
    step(1);
    MCL_n = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
